// File: rtl/om_pkg.sv
// Shared types and helpers for the overflow-monitor range store.
package om_pkg;

    localparam int OM_ADDR_W    = 32;
    localparam int OM_DEPTH_DEF = 32;

    typedef struct packed {
        logic [OM_ADDR_W-1:0] first;
        logic [OM_ADDR_W-1:0] last;
    } om_range_t;

    // Inclusive on both ends, unsigned.
    function automatic logic om_in_range(input logic [OM_ADDR_W-1:0] addr,
                                         input om_range_t             rng);
        return (rng.first <= addr) && (addr <= rng.last);
    endfunction

endpackage

// File: rtl/om_match_enc.sv
// Priority encoder: reduces a per-entry match vector to a hit flag and the lowest matching index.
module om_match_enc #(
    parameter int  N     = 32,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     match,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        hit = |match;
        idx = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (match[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/range_buffer_om.sv
// Circular store of {first,last} address ranges with per-entry valid bits,
// free-by-start-address, registered range lookup and occupancy tracking.
module range_buffer_om
    import om_pkg::*;
#(
    parameter int  ADDR_W    = 32,
    parameter int  DEPTH     = OM_DEPTH_DEF,
    parameter bit  OVERWRITE = 1'b1,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int CNT_W     = IDX_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_first_i,
    input  logic [ADDR_W-1:0] wr_last_i,
    output logic              wr_ready_o,
    output logic              wr_err_o,
    output logic              evict_o,
    input  logic              free_valid_i,
    input  logic [ADDR_W-1:0] free_addr_i,
    output logic              free_hit_o,
    input  logic              lk_valid_i,
    input  logic [ADDR_W-1:0] lk_addr_i,
    output logic              lk_valid_o,
    output logic              lk_hit_o,
    output logic [IDX_W-1:0]  lk_idx_o,
    output logic [ADDR_W-1:0] last_first_o,
    output logic [ADDR_W-1:0] last_last_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [ADDR_W-1:0] first_q [DEPTH];
    logic [ADDR_W-1:0] last_q  [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [IDX_W-1:0]  cursor_q;
    logic [CNT_W-1:0]  count_q;

    om_range_t         ent [DEPTH];
    logic [DEPTH-1:0]  lk_match;
    logic [DEPTH-1:0]  free_match;
    logic              lk_hit;
    logic [IDX_W-1:0]  lk_idx;
    logic              free_hit;
    logic [IDX_W-1:0]  free_idx;

    logic slot_busy, wr_fire, wr_ok, wr_bad, same_slot, cnt_inc, cnt_dec;

    // Entries are widened to the package address width for the range compare;
    // ADDR_W is expected not to exceed OM_ADDR_W.
    always_comb begin
        lk_match   = '0;
        free_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent[i].first  = OM_ADDR_W'(first_q[i]);
            ent[i].last   = OM_ADDR_W'(last_q[i]);
            lk_match[i]   = valid_q[i] && om_in_range(OM_ADDR_W'(lk_addr_i), ent[i]);
            free_match[i] = free_valid_i && valid_q[i] && (first_q[i] == free_addr_i);
        end
    end

    om_match_enc #(.N(DEPTH)) u_lk_enc (
        .match (lk_match),
        .hit   (lk_hit),
        .idx   (lk_idx)
    );

    om_match_enc #(.N(DEPTH)) u_free_enc (
        .match (free_match),
        .hit   (free_hit),
        .idx   (free_idx)
    );

    assign slot_busy  = valid_q[cursor_q];
    assign wr_ready_o = !rst_i && (OVERWRITE || !slot_busy);
    assign wr_fire    = wr_valid_i && wr_ready_o;
    assign wr_ok      = wr_fire && (wr_first_i <= wr_last_i);
    assign wr_bad     = wr_fire && (wr_first_i > wr_last_i);
    // A free aimed at the slot being rewritten counts as a hit but the slot stays occupied.
    assign same_slot  = wr_ok && free_hit && (free_idx == cursor_q);
    assign cnt_inc    = wr_ok && !slot_busy;
    assign cnt_dec    = free_hit && !same_slot;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                first_q[i] <= '0;
                last_q[i]  <= '0;
            end
            valid_q      <= '0;
            cursor_q     <= '0;
            count_q      <= '0;
            wr_err_o     <= 1'b0;
            evict_o      <= 1'b0;
            free_hit_o   <= 1'b0;
            lk_valid_o   <= 1'b0;
            lk_hit_o     <= 1'b0;
            lk_idx_o     <= '0;
            last_first_o <= '0;
            last_last_o  <= '0;
        end else begin
            if (free_hit) valid_q[free_idx] <= 1'b0;
            if (wr_ok) begin
                first_q[cursor_q] <= wr_first_i;
                last_q[cursor_q]  <= wr_last_i;
                valid_q[cursor_q] <= 1'b1;
                cursor_q          <= cursor_q + IDX_W'(1);
                last_first_o      <= wr_first_i;
                last_last_o       <= wr_last_i;
            end
            count_q    <= count_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
            wr_err_o   <= wr_bad;
            evict_o    <= wr_ok && slot_busy && !same_slot;
            free_hit_o <= free_hit;
            lk_valid_o <= lk_valid_i;
            lk_hit_o   <= lk_valid_i && lk_hit;
            lk_idx_o   <= lk_valid_i ? lk_idx : '0;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_range_buffer_om.sv
// Bench for range_buffer_om: two DEPTH=4 instances (overwrite on / off) checked every cycle against a behavioural model.
module tb_range_buffer_om;

    localparam int AW = 32;
    localparam int D  = 4;
    localparam int IW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;

    logic          wv [2];
    logic [AW-1:0] wf [2];
    logic [AW-1:0] wl [2];
    logic          fv [2];
    logic [AW-1:0] fa [2];
    logic          lv [2];
    logic [AW-1:0] la [2];

    logic          rdy [2];
    logic          err [2];
    logic          evc [2];
    logic          fh  [2];
    logic          lkv [2];
    logic          lkh [2];
    logic [IW-1:0] lki [2];
    logic [AW-1:0] lf  [2];
    logic [AW-1:0] ll  [2];
    logic [CW-1:0] cnt [2];
    logic          full  [2];
    logic          empty [2];

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    range_buffer_om #(.ADDR_W(AW), .DEPTH(D), .OVERWRITE(1'b1)) u_dut_ow (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wv[0]), .wr_first_i(wf[0]), .wr_last_i(wl[0]),
        .wr_ready_o(rdy[0]), .wr_err_o(err[0]), .evict_o(evc[0]),
        .free_valid_i(fv[0]), .free_addr_i(fa[0]), .free_hit_o(fh[0]),
        .lk_valid_i(lv[0]), .lk_addr_i(la[0]),
        .lk_valid_o(lkv[0]), .lk_hit_o(lkh[0]), .lk_idx_o(lki[0]),
        .last_first_o(lf[0]), .last_last_o(ll[0]),
        .count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0])
    );

    range_buffer_om #(.ADDR_W(AW), .DEPTH(D), .OVERWRITE(1'b0)) u_dut_no (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wv[1]), .wr_first_i(wf[1]), .wr_last_i(wl[1]),
        .wr_ready_o(rdy[1]), .wr_err_o(err[1]), .evict_o(evc[1]),
        .free_valid_i(fv[1]), .free_addr_i(fa[1]), .free_hit_o(fh[1]),
        .lk_valid_i(lv[1]), .lk_addr_i(la[1]),
        .lk_valid_o(lkv[1]), .lk_hit_o(lkh[1]), .lk_idx_o(lki[1]),
        .last_first_o(lf[1]), .last_last_o(ll[1]),
        .count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1])
    );

    // ---------------- behavioural model ----------------
    bit            mv  [2][D];
    logic [AW-1:0] mf  [2][D];
    logic [AW-1:0] ml  [2][D];
    int            mcur [2];
    bit            e_err [2], e_evc [2], e_fh [2], e_lkv [2], e_lkh [2];
    int            e_lki [2];
    logic [AW-1:0] e_lf [2], e_ll [2];

    function automatic bit is_ow(input int u);
        return (u == 0);
    endfunction

    function automatic int popcount(input int u);
        int n = 0;
        for (int i = 0; i < D; i++) n += int'(mv[u][i]);
        return n;
    endfunction

    always @(posedge clk) begin : model
        bit fire, ok, fhit, lhit, same;
        int fidx, lidx;
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                for (int i = 0; i < D; i++) begin
                    mv[u][i] = 1'b0; mf[u][i] = '0; ml[u][i] = '0;
                end
                mcur[u] = 0;
                e_err[u] = 0; e_evc[u] = 0; e_fh[u] = 0;
                e_lkv[u] = 0; e_lkh[u] = 0; e_lki[u] = 0;
                e_lf[u] = '0; e_ll[u] = '0;
                started = 1'b1;
            end else begin
                fire = wv[u] && (is_ow(u) || !mv[u][mcur[u]]);
                ok   = fire && (wf[u] <= wl[u]);
                fhit = 0; fidx = 0; lhit = 0; lidx = 0;
                for (int i = 0; i < D; i++) begin
                    if (!fhit && fv[u] && mv[u][i] && mf[u][i] == fa[u]) begin
                        fhit = 1; fidx = i;
                    end
                    if (!lhit && mv[u][i] && mf[u][i] <= la[u] && la[u] <= ml[u][i]) begin
                        lhit = 1; lidx = i;
                    end
                end
                same     = ok && fhit && (fidx == mcur[u]);
                e_err[u] = fire && !ok;
                e_evc[u] = ok && mv[u][mcur[u]] && !same;
                e_fh[u]  = fhit;
                e_lkv[u] = lv[u];
                e_lkh[u] = lv[u] && lhit;
                e_lki[u] = (lv[u] && lhit) ? lidx : 0;
                if (fhit) mv[u][fidx] = 1'b0;
                if (ok) begin
                    mf[u][mcur[u]] = wf[u];
                    ml[u][mcur[u]] = wl[u];
                    mv[u][mcur[u]] = 1'b1;
                    e_lf[u] = wf[u];
                    e_ll[u] = wl[u];
                    mcur[u] = (mcur[u] + 1) % D;
                end
            end
        end
    end

    task automatic chk(input string nm, input int u, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%0h required=%0h at %0t", nm, u, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (started) begin
            for (int u = 0; u < 2; u++) begin
                chk("wr_ready", u, 64'(rdy[u]), 64'(!rst && (is_ow(u) || !mv[u][mcur[u]])));
                chk("wr_err",   u, 64'(err[u]), 64'(e_err[u]));
                chk("evict",    u, 64'(evc[u]), 64'(e_evc[u]));
                chk("free_hit", u, 64'(fh[u]),  64'(e_fh[u]));
                chk("lk_valid", u, 64'(lkv[u]), 64'(e_lkv[u]));
                chk("lk_hit",   u, 64'(lkh[u]), 64'(e_lkh[u]));
                chk("lk_idx",   u, 64'(lki[u]), 64'(e_lki[u]));
                chk("last_first", u, 64'(lf[u]), 64'(e_lf[u]));
                chk("last_last",  u, 64'(ll[u]), 64'(e_ll[u]));
                chk("count", u, 64'(cnt[u]),   64'(popcount(u)));
                chk("full",  u, 64'(full[u]),  64'(popcount(u) == D));
                chk("empty", u, 64'(empty[u]), 64'(popcount(u) == 0));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clr();
        for (int u = 0; u < 2; u++) begin
            wv[u] = 0; wf[u] = '0; wl[u] = '0;
            fv[u] = 0; fa[u] = '0;
            lv[u] = 0; la[u] = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wr(input int u, input logic [AW-1:0] f, input logic [AW-1:0] l);
        wv[u] = 1; wf[u] = f; wl[u] = l;
    endtask

    task automatic fr(input int u, input logic [AW-1:0] a);
        fv[u] = 1; fa[u] = a;
    endtask

    task automatic lk(input int u, input logic [AW-1:0] a);
        lv[u] = 1; la[u] = a;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick(); tick();
        chk("rst_count", 0, 64'(cnt[0]), 0);
        chk("rst_empty", 0, 64'(empty[0]), 1);
        rst = 1'b0;

        // basic write and lookup boundaries
        clr(); wr(0, 'h1000, 'h10FF); tick();
        chk("t1_count", 0, 64'(cnt[0]), 1);
        chk("t1_last_first", 0, 64'(lf[0]), 'h1000);
        clr(); lk(0, 'h10FF); tick();
        chk("t1_hit_edge", 0, 64'(lkh[0]), 1);
        chk("t1_idx", 0, 64'(lki[0]), 0);
        clr(); lk(0, 'h1100); tick();
        chk("t1_miss_valid", 0, 64'(lkv[0]), 1);
        chk("t1_miss", 0, 64'(lkh[0]), 0);

        // overwrite wrap
        clr(); wr(0, 'h2000, 'h20FF); tick();
        clr(); wr(0, 'h3000, 'h30FF); tick();
        clr(); wr(0, 'h4000, 'h40FF); tick();
        chk("t2_full4", 0, 64'(full[0]), 1);
        clr(); wr(0, 'h5000, 'h50FF); tick();
        chk("t2_evict", 0, 64'(evc[0]), 1);
        chk("t2_count", 0, 64'(cnt[0]), 4);
        clr(); lk(0, 'h1080); tick();
        chk("t2_old_miss", 0, 64'(lkh[0]), 0);
        clr(); lk(0, 'h5010); tick();
        chk("t2_new_idx", 0, 64'(lki[0]), 0);

        // malformed write and unmatched free
        clr(); wr(0, 'h2000, 'h1FFF); tick();
        chk("t4_err", 0, 64'(err[0]), 1);
        chk("t4_count", 0, 64'(cnt[0]), 4);
        chk("t4_last_first", 0, 64'(lf[0]), 'h5000);
        clr(); fr(0, 'hDEAD); tick();
        chk("t4_free_miss", 0, 64'(fh[0]), 0);
        clr(); wr(0, 'h6000, 'h60FF); tick();
        chk("t4_evict1", 0, 64'(evc[0]), 1);
        clr(); lk(0, 'h6010); tick();
        chk("t4_cursor_kept", 0, 64'(lki[0]), 1);

        // write + free of the same slot (cursor 2), lookup sees old data
        clr(); wr(0, 'h7000, 'h70FF); fr(0, 'h3000); lk(0, 'h3010); tick();
        chk("t5_free_hit", 0, 64'(fh[0]), 1);
        chk("t5_no_evict", 0, 64'(evc[0]), 0);
        chk("t5_count", 0, 64'(cnt[0]), 4);
        chk("t5_old_hit", 0, 64'(lkh[0]), 1);
        chk("t5_old_idx", 0, 64'(lki[0]), 2);
        clr(); lk(0, 'h7050); tick();
        chk("t5_new_idx", 0, 64'(lki[0]), 2);
        clr(); lk(0, 'h3010); tick();
        chk("t5_old_gone", 0, 64'(lkh[0]), 0);

        // overlapping ranges, then reset with a lookup in flight
        clr(); wr(0, 'h6080, 'h6FFF); tick();
        clr(); lk(0, 'h6090); tick();
        chk("t6_overlap_idx", 0, 64'(lki[0]), 1);
        clr(); lk(0, 'h6090); rst = 1'b1; tick();
        chk("t6_rst_lkv", 0, 64'(lkv[0]), 0);
        chk("t6_rst_count", 0, 64'(cnt[0]), 0);
        chk("t6_rst_last", 0, 64'(lf[0]), 0);
        chk("t6_rst_ready", 0, 64'(rdy[0]), 0);
        rst = 1'b0;

        // no-overwrite: refusal, free, retry
        for (int i = 0; i < 4; i++) begin
            clr(); wr(1, 32'('hA000 + i * 'h100), 32'('hA0FF + i * 'h100)); tick();
        end
        chk("t3_full", 1, 64'(full[1]), 1);
        clr(); wr(1, 'hE000, 'hE0FF); #1;
        chk("t3_refused", 1, 64'(rdy[1]), 0);
        tick();
        chk("t3_count_held", 1, 64'(cnt[1]), 4);
        chk("t3_last_held", 1, 64'(lf[1]), 'hA300);
        clr(); wr(1, 'hE000, 'hE0FF); fr(1, 'hA000); tick();
        chk("t3_free_hit", 1, 64'(fh[1]), 1);
        chk("t3_count3", 1, 64'(cnt[1]), 3);
        chk("t3_ready_again", 1, 64'(rdy[1]), 1);
        clr(); wr(1, 'hE000, 'hE0FF); tick();
        chk("t3_count4", 1, 64'(cnt[1]), 4);
        chk("t3_last_first", 1, 64'(lf[1]), 'hE000);
        clr(); lk(1, 'hE010); tick();
        chk("t3_slot0", 1, 64'(lki[1]), 0);
        chk("t3_hit", 1, 64'(lkh[1]), 1);

        clr(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
